// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame geometry.
package uart_pkg;

    // Number of data bits carried by one 8N1 frame.
    localparam int unsigned DATA_BITS = 8;

    // Width of the receiver state encoding.
    localparam int unsigned STATE_W = 4;

    // Receiver states. The data states are contiguous so the next data state is state + 1.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        BIT_0 = 4'd2,
        BIT_1 = 4'd3,
        BIT_2 = 4'd4,
        BIT_3 = 4'd5,
        BIT_4 = 4'd6,
        BIT_5 = 4'd7,
        BIT_6 = 4'd8,
        BIT_7 = 4'd9,
        STOP  = 4'd10,
        BREAK = 4'd11
    } rx_state_t;

    // Successor of a data-bit state. BIT_7 is followed by STOP.
    function automatic rx_state_t next_data_state(input rx_state_t s);
        rx_state_t n;
        if (s == BIT_7) begin
            n = STOP;
        end else begin
            n = rx_state_t'(STATE_W'(s) + STATE_W'(1));
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset value.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_async,
    output logic o_sync
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            meta   <= RST_VAL;
            o_sync <= RST_VAL;
        end else begin
            meta   <= i_async;
            o_sync <= meta;
        end
    end

endmodule

// File: rtl/ref_uart_rx.sv
// Reference 8N1 UART receiver: mid-bit sampling, glitch-start rejection, framing-error flag.
module ref_uart_rx
    import uart_pkg::*;
#(
    parameter logic [23:0] CLKS_PER_BAUD = 24'd868
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_uart_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BAUD) + 1;

    // Half a bit lands the first sample in the middle of the start bit.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BAUD / 24'd2 - 24'd1);
    // Full bit period between successive mid-bit samples.
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BAUD - 24'd1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 tick;

    uart_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_async (i_uart_rx),
        .o_sync  (rx_s)
    );

    // Sample point reached; only acted on outside IDLE.
    assign tick = (cnt == '0);

    // Receiver FSM with baud down-counter, shift register and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;

            if ((state != IDLE) && !tick) begin
                cnt <= cnt - CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt    <= HALF_LOAD;
                        o_busy <= 1'b1;
                        state  <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        if (rx_s) begin
                            // Line went back high before mid-start: treat as a glitch.
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            cnt   <= FULL_LOAD;
                            state <= BIT_0;
                        end
                    end
                end

                BIT_0, BIT_1, BIT_2, BIT_3, BIT_4, BIT_5, BIT_6, BIT_7: begin
                    if (tick) begin
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        cnt   <= FULL_LOAD;
                        state <= next_data_state(state);
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            // Return to IDLE mid-stop so a following start edge is not missed.
                            o_data  <= shift;
                            o_valid <= 1'b1;
                            o_busy  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= BREAK;
                        end
                    end
                end

                BREAK: begin
                    // Hold off until the line recovers so a break is not read as 0x00 bytes.
                    if (rx_s) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ref_uart_rx.sv
// Self-checking bench for ref_uart_rx: table of frames plus glitch and reset sequences.
module tb_ref_uart_rx;

    localparam int unsigned N   = 16;
    localparam int          LAT = 3 + (N / 2) + 9 * N;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       busy;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        bit         exp_valid;
        bit         exp_ferr;
        int         extra_low_baud;
        int         idle_baud;
        logic [7:0] exp_data;
    } vec_t;

    exp_t       sb[$];
    exp_t       got;
    int         exp_ferr_cnt = 0;
    logic [7:0] last_good    = 8'h00;
    bit         prev_pulse   = 1'b0;
    int         lat;
    vec_t       vecs[6];

    ref_uart_rx #(
        .CLKS_PER_BAUD (24'd16)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_uart_rx   (rx),
        .o_data      (data),
        .o_valid     (valid),
        .o_frame_err (ferr),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic drive_for(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Transmit one frame; good frames are queued for the monitor at the start edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit expect_good);
        exp_t e;
        rx = 1'b0;
        if (expect_good) begin
            e.data  = d;
            e.start = cyc;
            sb.push_back(e);
        end
        repeat (N) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) drive_for(d[i], N);
        drive_for(stop_bit, N);
    endtask

    // Scoreboard monitor: compares every output pulse against the expected queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (valid && ferr) chk(1'b0, "valid_ferr_exclusive", 32'd1, 32'd0);
            if ((valid || ferr) && prev_pulse) chk(1'b0, "pulse_consecutive", 32'd1, 32'd0);
            if (valid) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_valid", 32'(data), 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk(data == got.data, "valid_data", 32'(data), 32'(got.data));
                    lat = cyc - got.start;
                    chk((lat >= LAT - 2) && (lat <= LAT + 2), "valid_latency", 32'(lat), 32'(LAT));
                    last_good = got.data;
                end
            end
            if (ferr) begin
                if (exp_ferr_cnt == 0) begin
                    chk(1'b0, "unexpected_frame_err", 32'd1, 32'd0);
                end else begin
                    exp_ferr_cnt--;
                    chk(data == last_good, "ferr_data_hold", 32'(data), 32'(last_good));
                end
            end
            prev_pulse = valid || ferr;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 0, 1, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 0, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 0, 0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 0, 1, 8'h3C};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b1, 2, 1, 8'h3C};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b0, 0, 1, 8'h81};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk(data == 8'h00, "reset_data", 32'(data), 32'h0);
        chk(valid == 1'b0, "reset_valid", 32'(valid), 32'h0);
        chk(ferr == 1'b0, "reset_ferr", 32'(ferr), 32'h0);
        chk(busy == 1'b0, "reset_busy", 32'(busy), 32'h0);
        rstn = 1'b1;
        drive_for(1'b1, 2 * N);

        // Table-driven frames: loopback, back-to-back, framing error, recovery
        foreach (vecs[v]) begin
            if (vecs[v].exp_ferr) exp_ferr_cnt++;
            send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].exp_valid);
            if (vecs[v].extra_low_baud > 0) begin
                drive_for(1'b0, vecs[v].extra_low_baud * N);
                chk(busy == 1'b1, "busy_in_break", 32'(busy), 32'h1);
            end
            if (vecs[v].idle_baud > 0) begin
                drive_for(1'b1, vecs[v].idle_baud * N);
                chk(busy == 1'b0, "busy_after_frame", 32'(busy), 32'h0);
            end
            chk(data == vecs[v].exp_data, "data_after_frame", 32'(data), 32'(vecs[v].exp_data));
        end
        chk(sb.size() == 0, "sb_empty_after_table", 32'(sb.size()), 32'h0);
        chk(exp_ferr_cnt == 0, "ferr_seen", 32'(exp_ferr_cnt), 32'h0);

        // Glitch start: 4 cycles low
        align();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk(busy == 1'b1, "glitch_busy_set", 32'(busy), 32'h1);
        rx = 1'b1;
        k = 0;
        while (busy && (k < 12)) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(busy == 1'b0, "glitch_busy_clear", 32'(busy), 32'h0);
        drive_for(1'b1, 2 * N);
        chk(data == 8'h81, "glitch_data_hold", 32'(data), 32'h81);

        // Reset during BIT_4 of 0xC3
        rx = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] c3;
            c3 = 8'hC3;
            drive_for(c3[i], N);
        end
        drive_for(1'b0, 5);
        rstn = 1'b0;
        #1;
        chk(data == 8'h00, "midreset_data", 32'(data), 32'h0);
        chk(valid == 1'b0, "midreset_valid", 32'(valid), 32'h0);
        chk(ferr == 1'b0, "midreset_ferr", 32'(ferr), 32'h0);
        chk(busy == 1'b0, "midreset_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b1;
        drive_for(1'b1, 2 * N);
        send_frame(8'h12, 1'b1, 1'b1);
        drive_for(1'b1, N);
        chk(data == 8'h12, "post_reset_data", 32'(data), 32'h12);
        chk(busy == 1'b0, "post_reset_busy", 32'(busy), 32'h0);
        chk(sb.size() == 0, "sb_empty_final", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ref_uart_rx.md
Name: ref_uart_rx

Overview:
Reference UART receiver for the loopback testbench. It sits directly downstream of the reference transmitter and consumes its serial line: 8N1 frames, LSB first, idle-high. The block recovers each byte by sampling at mid-bit and presents it on a parallel port with a one-cycle valid pulse. It flags framing errors and rejects glitch start bits.

Parameters:
CLKS_PER_BAUD, 24'd868, clock cycles per bit period. Minimum 4. Must match the transmitter's value.

Ports:
i_clk  input  1  system clock
i_rstn  input  1  asynchronous, active-low reset
i_uart_rx  input  1  serial line in; idle high; asynchronous to i_clk
o_data  output  8  last correctly received byte; holds until the next good frame
o_valid  output  1  one-cycle pulse; o_data is new in this cycle
o_frame_err  output  1  one-cycle pulse; stop bit was sampled low
o_busy  output  1  high from start-bit detect until return to IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rstn is asynchronous and active-low. All flops clear immediately on i_rstn low.
- Reset values: o_data=8'h00, o_valid=0, o_frame_err=0, o_busy=0, state=IDLE, shift register=8'h00, baud counter=0. Synchronizer flops reset to 1 (line idle).
- Synchronizer: i_uart_rx passes through 2 flops to give rx_s. All logic uses rx_s only.
- Counter: one down-counter, width $clog2(CLKS_PER_BAUD)+1. A "tick" occurs when the counter is 0 in a non-IDLE state. On each tick the counter reloads per the transition taken.
- State IDLE: if rx_s==0, load the counter with CLKS_PER_BAUD/2-1 (integer divide), set o_busy=1, go to START.
- State START, on tick: if rx_s==1 (glitch), go to IDLE, clear o_busy, assert no output. Otherwise load CLKS_PER_BAUD-1 and go to BIT_0.
- States BIT_0..BIT_7, on tick: shift <= {rx_s, shift[7:1]}, load CLKS_PER_BAUD-1, advance. BIT_7 advances to STOP.
- State STOP, on tick:
  - rx_s==1: o_data<=shift, o_valid=1 for one cycle, go to IDLE, clear o_busy.
  - rx_s==0: o_frame_err=1 for one cycle, o_data unchanged, go to BREAK.
- State BREAK: wait until rx_s==1, then go to IDLE and clear o_busy. This prevents a held-low line or break condition from being decoded as a 0x00 stream.
- o_valid and o_frame_err are mutually exclusive and never high for two consecutive cycles.
- Latency: o_valid rises 3 + CLKS_PER_BAUD/2 + 9*CLKS_PER_BAUD cycles after the i_uart_rx falling edge.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so the next start edge, even one immediately after a 1-baud stop, is detected with no lost frame.
- No FIFO and no ready input. A byte not consumed before the next o_valid is overwritten. This is by design.
- Reset mid-frame: the partial byte is discarded, no pulse is produced, and the block returns to IDLE. If the line is low when reset releases, the block enters START and the glitch/frame logic resolves it.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, START, BIT_0..BIT_7, STOP, BREAK) and localparam DATA_BITS=8.
- Sub-module uart_sync: a 2-flop synchronizer with a reset-value parameter. It is reused later for other async inputs.

Test Plan:
- Loopback: ref_uart_tx -> ref_uart_rx, CLKS_PER_BAUD=16, write 8'hA5 -> exactly one o_valid, o_data=8'hA5, at 3+8+144=155 cycles after the tx falling edge (bench tolerance ±2).
- Back-to-back writes 8'h00, 8'hFF, 8'h3C (tx re-written as soon as o_busy falls) -> three o_valid pulses in order with matching data, o_frame_err never high.
- Glitch: drive i_uart_rx low for 4 cycles (CLKS_PER_BAUD=16), then high -> no o_valid, no o_frame_err, o_busy returns to 0 within 12 cycles.
- Framing error: hand-drive start + 8'h55 + stop=0, held low 3 baud, then high -> one o_frame_err, o_data keeps its previous value, o_busy high until the line rises, then a following good frame 8'h81 is received correctly.
- Reset mid-frame: assert i_rstn low during BIT_4 of 8'hC3 -> all outputs 0 immediately, no pulse. After release, the next frame 8'h12 is received correctly.
